// File: rtl/slider_digit_entry_if.sv
// Bundle between the switch front end and the calculator operand path:
// slider/mode/clear controls going in, operands and step/sat pulses coming out.
interface slider_digit_entry_if #(
    parameter int NUM_DIGITS   = 4,
    parameter int NUM_OPERANDS = 2,
    parameter int VAL_W        = 14,
    parameter int SEL_W        = 1
) ();
    logic [NUM_DIGITS-1:0]         slider;
    logic                          dir;
    logic [SEL_W-1:0]              sel;
    logic                          clr;
    logic                          clr_all;
    logic [NUM_OPERANDS*VAL_W-1:0] operands;
    logic                          step;
    logic                          sat;

    modport master (output slider, dir, sel, clr, clr_all,
                    input  operands, step, sat);
    modport slave  (input  slider, dir, sel, clr, clr_all,
                    output operands, step, sat);
endinterface

// File: rtl/slider_digit_entry.sv
// Slider number entry: slider k steps operand[sel] by +/-10^k, with
// press-and-hold auto-repeat and saturation at 0 / MAX_VALUE.
module slider_digit_entry #(
    parameter int NUM_DIGITS    = 4,
    parameter int NUM_OPERANDS  = 2,
    parameter int MAX_VALUE     = 9999,
    parameter int VAL_W         = 14,
    parameter int FIRST_DELAY   = 50000000,
    parameter int REPEAT_PERIOD = 32500000,
    parameter int SEL_W         = 1
) (
    input logic                 clk,
    input logic                 rst,
    slider_digit_entry_if.slave bus
);
    localparam int WW    = VAL_W + 2;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMAX  = (FIRST_DELAY > REPEAT_PERIOD) ? FIRST_DELAY : REPEAT_PERIOD;
    localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [WW-1:0]    MAX_W       = WW'(MAX_VALUE);
    localparam logic [VAL_W-1:0] MAX_V       = VAL_W'(MAX_VALUE);
    localparam logic [TW-1:0]    FIRST_LOAD  = TW'(FIRST_DELAY - 1);
    localparam logic [TW-1:0]    REPEAT_LOAD = TW'(REPEAT_PERIOD - 1);
    localparam logic [SEL_W:0]   NOPS        = (SEL_W+1)'(NUM_OPERANDS);

    typedef enum logic [1:0] {IDLE, FIRST, REPEAT, LOCK} state_e;

    function automatic logic [WW-1:0] pow10(input int k);
        logic [WW-1:0] p;
        p = WW'(1);
        for (int i = 0; i < k; i++) p = p * WW'(10);
        return p;
    endfunction

    state_e                                state_q;
    logic [TW-1:0]                         timer_q;
    logic [NUM_DIGITS-1:0]                 slider_q;
    logic [IDX_W-1:0]                      act_q;
    logic [NUM_OPERANDS-1:0][VAL_W-1:0]    ops_q;
    logic                                  step_q;
    logic                                  sat_q;

    logic [IDX_W-1:0] act;
    logic             act_vld;
    logic             sel_ok;
    logic [VAL_W-1:0] cur;
    logic [WW-1:0]    cur_w;
    logic [WW-1:0]    weight;
    logic [VAL_W-1:0] op_d;
    logic             sat_d;
    logic             step_d;

    // Descending scan so the lowest set slider wins.
    always_comb begin
        act     = '0;
        act_vld = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (slider_q[i]) begin
                act     = IDX_W'(i);
                act_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ok = ({1'b0, bus.sel} < NOPS);
        cur    = '0;
        for (int m = 0; m < NUM_OPERANDS; m++)
            if (bus.sel == SEL_W'(m)) cur = ops_q[m];
        weight = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (act == IDX_W'(i)) weight = pow10(i);
        cur_w = WW'(cur);
        // Two spare bits keep v + w exact before the clamp compare.
        if (bus.dir) begin
            sat_d = (weight > cur_w);
            op_d  = sat_d ? '0 : VAL_W'(cur_w - weight);
        end else begin
            sat_d = ((cur_w + weight) > MAX_W);
            op_d  = sat_d ? MAX_V : VAL_W'(cur_w + weight);
        end
    end

    always_comb begin
        step_d = 1'b0;
        case (state_q)
            IDLE:          step_d = act_vld;
            FIRST, REPEAT: step_d = act_vld && ((act != act_q) || (timer_q == '0));
            default:       step_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            slider_q <= '0;
            act_q    <= '0;
            ops_q    <= '0;
            step_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            slider_q <= bus.slider;
            act_q    <= act;
            step_q   <= 1'b0;
            sat_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (act_vld) begin
                        state_q <= FIRST;
                        timer_q <= FIRST_LOAD;
                    end
                end
                FIRST, REPEAT: begin
                    if (!act_vld) begin
                        state_q <= IDLE;
                    end else if (act != act_q) begin
                        state_q <= FIRST;
                        timer_q <= FIRST_LOAD;
                    end else if (timer_q == '0) begin
                        state_q <= REPEAT;
                        timer_q <= REPEAT_LOAD;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    if (!act_vld) state_q <= IDLE;
                end
            endcase
            // A clear swallows any coincident step; a still-held slider is locked out.
            if (bus.clr_all || bus.clr) begin
                state_q <= act_vld ? LOCK : IDLE;
                for (int m = 0; m < NUM_OPERANDS; m++)
                    if (bus.clr_all || (bus.clr && bus.sel == SEL_W'(m))) ops_q[m] <= '0;
            end else if (step_d && sel_ok) begin
                for (int m = 0; m < NUM_OPERANDS; m++)
                    if (bus.sel == SEL_W'(m)) ops_q[m] <= op_d;
                step_q <= 1'b1;
                sat_q  <= sat_d;
            end
        end
    end

    assign bus.operands = ops_q;
    assign bus.step     = step_q;
    assign bus.sat      = sat_q;
endmodule

// File: doc/slider_digit_entry.md
Name: slider_digit_entry

Overview:
- Parametrised successor to the calculator's slider number-entry block.
- N slider inputs each step one decimal digit position (slider k adds or subtracts 10^k) of one of M operand registers.
- Supports press-and-hold auto-repeat with a first-repeat delay, an increment/decrement mode, and saturation at 0 and MAX_VALUE. There is no wrap and no overflow-reset.
- Sits between the debounced/synchronised switch inputs and the calculator ALU/display path.

Parameters:
- NUM_DIGITS, 4: number of sliders; slider k weights 10^k (k = 0..NUM_DIGITS-1).
- NUM_OPERANDS, 2: number of operand registers, M ≥ 1.
- MAX_VALUE, 9999: saturation ceiling; must be ≥ 10^(NUM_DIGITS-1).
- VAL_W, 14: operand width; must be ≥ $clog2(MAX_VALUE+1).
- FIRST_DELAY, 50000000: cycles from the first step to the second step of a hold; ≥ 1.
- REPEAT_PERIOD, 32500000: cycles between steps after the second step; ≥ 1.
- SEL_W, 1: selector width, = max(1, $clog2(NUM_OPERANDS)).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- slider  in  NUM_DIGITS  level inputs, already synchronised; bit k = digit k
- dir  in  1  0 = increment, 1 = decrement; sampled on each step
- sel  in  SEL_W  target operand index; values ≥ NUM_OPERANDS are ignored (no step)
- clr  in  1  clear operand[sel] to 0
- clr_all  in  1  clear all operands to 0
- operands  out  NUM_OPERANDS*VAL_W  operand m at bits [m*VAL_W +: VAL_W]
- step  out  1  one-cycle pulse in the cycle after any operand write caused by a slider
- sat  out  1  one-cycle pulse, coincident with step, when the result was clamped

Behaviour:
- Reset: all operands = 0, step = 0, sat = 0, FSM = IDLE, timer = 0, slider_q = 0. rst has priority over all other inputs.
- Input register: slider_q <= slider every cycle.
- Active digit: the lowest set index of slider_q. No bit set means no slider active. Let act_q be the active index registered on the previous cycle.
- FSM states: IDLE, FIRST, REPEAT, LOCK.
  - IDLE, slider active: apply step immediately; go to FIRST; timer = FIRST_DELAY-1.
  - FIRST/REPEAT, no slider active: go to IDLE; no step.
  - FIRST/REPEAT, active index ≠ act_q: treat as a new press. Apply an immediate step with the new digit; go to FIRST; timer = FIRST_DELAY-1.
  - FIRST/REPEAT, timer = 0: apply step; go to REPEAT; timer = REPEAT_PERIOD-1.
  - FIRST/REPEAT, otherwise: timer decrements.
  - LOCK: hold until slider_q = 0, then go to IDLE. No steps are taken in LOCK.
- Hold timeline: slider asserted before edge E0 is captured in slider_q at E0.
  - First write at E1.
  - Second write at E1+FIRST_DELAY.
  - Later writes every REPEAT_PERIOD edges.
  - Each new value is visible after its edge; step/sat are high in the following cycle.
- Step arithmetic:
  - Weight w = 10^k, computed at full width ≥ VAL_W+1 with no truncation.
  - Increment: result = min(v + w, MAX_VALUE); sat = 1 if v + w > MAX_VALUE.
  - Decrement: result = max(v − w, 0); sat = 1 if w > v.
  - A step on a value already at its limit still pulses step and sat; the value is unchanged.
- sel: sampled at each step. Changing sel mid-hold redirects later steps without restarting the timer. An out-of-range sel suppresses the write and the step/sat pulses; the FSM still advances.
- Clears:
  - clr_all clears all operands. clr clears operand[sel], or nothing if sel is out of range.
  - Either clear wins over a step in the same cycle: that step is discarded and step = 0.
  - Either clear forces FSM = LOCK if slider_q ≠ 0, otherwise IDLE. A held slider therefore cannot resume counting until it is released.
- Simultaneous sliders: only the lowest index counts. Releasing the lower slider while a higher one remains set counts as an index change and produces an immediate step.

Test Plan (FIRST_DELAY=4, REPEAT_PERIOD=2, defaults otherwise):
- Single tap: slider[0]=1 for 1 cycle, sel=0, dir=0 -> operand0 = 1, exactly one step pulse, operand1 = 0.
- Hold: slider[1]=1 held for 10 cycles from E0 -> writes at E1, E5, E7, E9; operand0 = 40; nothing more after release.
- Saturation: operand1 = 9500, sel=1, tap slider[3] -> operand1 = 9999, sat pulses. Then dir=1, tap slider[3] twice -> 8999, then 7999, sat = 0.
- Underflow: operand0 = 5, dir=1, tap slider[1] -> operand0 = 0, sat = 1.
- Clear during hold: hold slider[0], assert clr on the cycle of the E5 step -> operand0 = 0, no step pulse, no further steps until the slider is released and pressed again.
- Priority/index change: slider[2] and slider[0] both set -> +1 steps only. Drop slider[0] mid-hold -> immediate +100 step, and the timer restarts with FIRST_DELAY.
